// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory (sync write, async read).
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie instead of round-robin.
module dmem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD
);
    // state  | meaning
    // IDLE   | no access in flight; arbitrate and latch a command
    // ACCESS | drive the latched command onto the memory for one cycle
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          winner;
    logic          in_range;
    logic          access;

    assign in_range = (addr_q >> DEPTH_LOG2) == '0;
    assign access   = (state_q == ACCESS);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign winner = req0 ? 1'b0 : 1'b1;
`else
    logic last_q, last_d;
    assign winner = req0 ? (req1 ? ~last_q : 1'b0) : 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    id_d    = winner;
                    we_d    = winner ? we1 : we0;
                    addr_d  = winner ? addr1 : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                end
            end
            ACCESS: begin
                state_d = IDLE;
                // out-of-range reads still complete, returning zero alongside err
                if (!we_q) begin
                    if (id_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = in_range ? mem_RD : '0;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = in_range ? mem_RD : '0;
                    end
                end
                if (!in_range) begin
                    err0_d = ~id_q;
                    err1_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign mem_A   = access ? addr_q : '0;
    assign mem_WD  = access ? wdata_q : '0;
    assign mem_WE  = access & we_q & in_range;
    assign gnt0    = access & ~id_q;
    assign gnt1    = access & id_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word data memory attached.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    typedef struct packed {
        logic        rv;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] shadow [64];
    logic [31:0] mem [64];
    int          total = 0;
    int          bad = 0;
    int          we_cycles = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_WE) mem[mem_A[5:0]] <= mem_WD;
    assign mem_RD = mem[mem_A[5:0]];

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // scoreboard: every rvalid/err pulse must match the oldest expectation for that port
    always @(negedge clk) begin
        exp_t e0;
        exp_t e1;
        if (mem_WE) we_cycles++;
        if (rvalid0 || err0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sb0_unexpected rvalid0=%0b err0=%0b expected no pulse", rvalid0, err0);
            end else begin
                e0 = q0.pop_front();
                if (rvalid0 !== e0.rv || err0 !== e0.err || (e0.rv && rdata0 !== e0.data)) begin
                    bad++;
                    $display("FAIL sb0 got rv=%0b err=%0b data=%h expected rv=%0b err=%0b data=%h",
                             rvalid0, err0, rdata0, e0.rv, e0.err, e0.data);
                end
            end
        end
        if (rvalid1 || err1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected rvalid1=%0b err1=%0b expected no pulse", rvalid1, err1);
            end else begin
                e1 = q1.pop_front();
                if (rvalid1 !== e1.rv || err1 !== e1.err || (e1.rv && rdata1 !== e1.data)) begin
                    bad++;
                    $display("FAIL sb1 got rv=%0b err=%0b data=%h expected rv=%0b err=%0b data=%h",
                             rvalid1, err1, rdata1, e1.rv, e1.err, e1.data);
                end
            end
        end
    end

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic got, output logic we_seen, output logic [31:0] a_seen);
        exp_t e;
        logic inr;
        inr    = (a < 32'd64);
        e.rv   = ~we;
        e.err  = ~inr;
        e.data = (!we && inr) ? shadow[a[5:0]] : 32'h0;
        if (!we || !inr) begin
            if (p == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (we && inr) shadow[a[5:0]] = wd;
        @(posedge clk); #1;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        got = 1'b0; we_seen = 1'b0; a_seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (((p == 0) ? gnt0 : gnt1) === 1'b1) begin
                got = 1'b1; we_seen = mem_WE; a_seen = mem_A;
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h3333_3333;
        repeat (3) @(negedge clk);
        total++;
        if (mem_WE !== 1'b0 || gnt0 !== 1'b0) begin
            bad++; $display("FAIL reset_outputs mem_WE=%0b gnt0=%0b expected 0 0", mem_WE, gnt0);
        end
        total++;
        if (rdata0 !== 32'h0 || rvalid0 !== 1'b0) begin
            bad++; $display("FAIL reset_rdata rdata0=%h rvalid0=%0b expected 0", rdata0, rvalid0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b0) begin
            bad++; $display("FAIL reset_gnt_early gnt0=%0b expected 0", gnt0);
        end
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b1 || mem_WE !== 1'b1 || mem_A !== 32'd3) begin
            bad++; $display("FAIL reset_first_gnt gnt0=%0b mem_WE=%0b mem_A=%0d expected 1 1 3", gnt0, mem_WE, mem_A);
        end
        shadow[3] = 32'h3333_3333;
        @(posedge clk); #1 req0 = 1'b0;
    endtask

    task automatic test_write_read();
        logic got, wes;
        logic [31:0] as;
        int w0;
        w0 = we_cycles;
        issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, got, wes, as);
        @(negedge clk);
        total++;
        if (got !== 1'b1 || wes !== 1'b1 || as !== 32'd5) begin
            bad++; $display("FAIL wr_access got=%0b mem_WE=%0b mem_A=%0d expected 1 1 5", got, wes, as);
        end
        total++;
        if (we_cycles - w0 != 1) begin
            bad++; $display("FAIL wr_we_cycles %0d expected 1", we_cycles - w0);
        end
        total++;
        if (rvalid0 !== 1'b0) begin
            bad++; $display("FAIL wr_no_rvalid rvalid0=%0b expected 0", rvalid0);
        end
        issue(0, 1'b0, 32'd5, 32'h0, got, wes, as);
        @(negedge clk);
        total++;
        if (got !== 1'b1 || wes !== 1'b0 || rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_after_wr got=%0b we=%0b rvalid0=%0b rdata0=%h expected 1 0 1 deadbeef",
                            got, wes, rvalid0, rdata0);
        end
    endtask

    task automatic test_preload();
        logic got, wes;
        logic [31:0] as;
        logic [31:0] addrs [4];
        addrs[0] = 32'd0; addrs[1] = 32'd1; addrs[2] = 32'd2; addrs[3] = 32'd10;
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b1, addrs[i], 32'hA5A5_0000 + i * 32'h1111, got, wes, as);
            total++;
            if (got !== 1'b1 || wes !== 1'b1 || as !== addrs[i]) begin
                bad++; $display("FAIL preload_%0d got=%0b mem_WE=%0b mem_A=%0d expected 1 1 %0d",
                                i, got, wes, as, addrs[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int n, g, prev_cyc, exp_g;
        n = 0; prev_cyc = -10; exp_g = 0;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                g = gnt1 ? 1 : 0;
                e.rv = 1'b1; e.err = 1'b0;
                e.data = g ? shadow[2] : shadow[1];
                if (g == 1) q1.push_back(e);
                else q0.push_back(e);
                total++;
                if ((gnt0 && gnt1) || g != exp_g || (n > 0 && cyc - prev_cyc != 2)) begin
                    bad++; $display("FAIL rr_grant_%0d gnt0=%0b gnt1=%0b gap=%0d expected port %0d gap 2",
                                    n, gnt0, gnt1, cyc - prev_cyc, exp_g);
                end
`ifndef DMEM_ARB_FIXED_PRIO_EN
                exp_g = 1 - g;
`endif
                prev_cyc = cyc;
                n++;
                if (n == 6) begin
                    @(posedge clk); #1;
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (n != 6) begin
            bad++; $display("FAIL rr_count grants=%0d expected 6", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic got, wes;
        logic [31:0] as;
        issue(1, 1'b1, 32'd64, 32'h1234_5678, got, wes, as);
        @(negedge clk);
        total++;
        if (got !== 1'b1 || wes !== 1'b0 || err1 !== 1'b1 || rvalid1 !== 1'b0) begin
            bad++; $display("FAIL oor_write got=%0b mem_WE=%0b err1=%0b rvalid1=%0b expected 1 0 1 0",
                            got, wes, err1, rvalid1);
        end
        issue(0, 1'b0, 32'd0, 32'h0, got, wes, as);
        @(negedge clk);
        total++;
        if (rvalid0 !== 1'b1 || rdata0 !== shadow[0]) begin
            bad++; $display("FAIL oor_addr0_intact rvalid0=%0b rdata0=%h expected 1 %h", rvalid0, rdata0, shadow[0]);
        end
        issue(0, 1'b0, 32'd100, 32'h0, got, wes, as);
        @(negedge clk);
        total++;
        if (rvalid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0) begin
            bad++; $display("FAIL oor_read rvalid0=%0b err0=%0b rdata0=%h expected 1 1 0", rvalid0, err0, rdata0);
        end
    endtask

    task automatic test_reset_mid_access();
        logic got, wes;
        logic [31:0] as;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd10; wdata1 = 32'hCAFE_F00D;
        @(posedge clk); #2;
        total++;
        if (gnt1 !== 1'b1 || mem_WE !== 1'b1) begin
            bad++; $display("FAIL abort_access gnt1=%0b mem_WE=%0b expected 1 1", gnt1, mem_WE);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (mem_WE !== 1'b0 || gnt1 !== 1'b0) begin
            bad++; $display("FAIL abort_we_drop mem_WE=%0b gnt1=%0b expected 0 0", mem_WE, gnt1);
        end
        @(posedge clk); #1 req1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(1, 1'b0, 32'd10, 32'h0, got, wes, as);
        @(negedge clk);
        total++;
        if (rvalid1 !== 1'b1 || rdata1 !== shadow[10] || mem[10] !== shadow[10]) begin
            bad++; $display("FAIL abort_old_value rvalid1=%0b rdata1=%h mem10=%h expected 1 %h",
                            rvalid1, rdata1, mem[10], shadow[10]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_preload();
        test_round_robin();
        test_out_of_range();
        test_reset_mid_access();
        repeat (4) @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL sb_drain q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
